debouncer_boton_switches: RTL
=============================

Name: debouncer_boton_switches

Overview:
- Input conditioning stage between the board pins and the memory-mapped switches/button register.
- Synchronizes the raw push-button and the 16 slide switches into clk_i and filters contact bounce.
- Produces a clean one-cycle press pulse (pulso_boton_o) that feeds the register's pulso_boton_i, plus a debounced switch vector that feeds its switches_i.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a new level (10 ms at 100 MHz); legal range >= 2.
- SYNC_STAGES, 2, flip-flops in each synchronizer chain; legal range >= 2.
- SW_WIDTH, 16, number of slide switches.
- REPEAT_DELAY, 50000000, cycles held before the first auto-repeat pulse; used only with AUTOREPEAT_EN.
- REPEAT_PERIOD, 10000000, cycles between later auto-repeat pulses; used only with AUTOREPEAT_EN.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  reset; asynchronous, active-high.
- boton_i  input  1  raw, asynchronous, bouncing push-button (1 = pressed).
- switches_raw_i  input  SW_WIDTH  raw, asynchronous slide switches.
- pulso_boton_o  output  1  one-cycle pulse per accepted press.
- boton_estable_o  output  1  debounced button level.
- switches_o  output  SW_WIDTH  debounced switch vector.

Behaviour:
- Reset: all synchronizer flops = 0, button FSM = IDLE, all counters = 0, pulso_boton_o = 0, boton_estable_o = 0, switches_o = 0.
- Reset asserted mid-operation aborts any count in progress. No pulse is emitted during or on exit from reset.
- Synchronizers: SYNC_STAGES-deep chain per input bit. The FSM and switch filter use only the last stage (b_s, sw_s).
- Button FSM, counter cnt_b (width clog2(DEBOUNCE_CYCLES)):
  - IDLE: boton_estable_o = 0. If b_s = 1, go to PRESS_CHK with cnt_b = 1 (this edge is sample 1).
  - PRESS_CHK: if b_s = 0, go to IDLE with cnt_b = 0. Otherwise cnt_b++. On the edge that takes sample DEBOUNCE_CYCLES, go to PRESSED and register pulso_boton_o = 1.
  - PRESSED: boton_estable_o = 1. If b_s = 0, go to RELEASE_CHK with cnt_b = 1.
  - RELEASE_CHK: boton_estable_o stays 1. If b_s = 1, go back to PRESSED with no pulse. Otherwise cnt_b++. On sample DEBOUNCE_CYCLES, go to IDLE.
- pulso_boton_o is registered and high for exactly 1 cycle per press. A release never produces a pulse.
- Latency: if boton_i is stable high from edge 1, the commit happens at edge SYNC_STAGES+DEBOUNCE_CYCLES. pulso_boton_o and boton_estable_o are high in the following cycle; the pulse falls at the next edge.
- Glitch handling: any interruption shorter than DEBOUNCE_CYCLES samples restarts the count and produces no output change. cnt_b never wraps; it saturates at the commit.
- Switch filter, counter cnt_s:
  - If sw_s == switches_o, cnt_s = 0.
  - Otherwise, cnt_s++ while sw_s equals the value it held on the previous cycle; cnt_s restarts at 1 if sw_s changes again.
  - On sample DEBOUNCE_CYCLES, switches_o <= sw_s (whole vector at once) and cnt_s = 0.
  - Switch latency matches the button latency. Switches never generate pulses.
- Button and switch paths are independent; simultaneous events are handled in the same cycle with no interaction.

Optional Feature:
- Macro: AUTOREPEAT_EN.
- Defined:
  - A repeat counter cnt_r clears on entry to PRESSED and increments each cycle in PRESSED.
  - It holds its value in RELEASE_CHK and resumes if the FSM bounces back to PRESSED. It clears on entry to IDLE.
  - Extra one-cycle pulses occur when cnt_r reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles after that.
- Undefined: exactly one pulse per press; REPEAT_* parameters unused; no cnt_r logic is synthesized.

Test Plan:
- DEBOUNCE_CYCLES=8, SYNC_STAGES=2. Reset, then boton_i=1 stable from edge 1 -> pulso_boton_o high only in the cycle after edge 10; boton_estable_o=1 from the same cycle; exactly 1 pulse total.
- Bounce: boton_i toggles 1,0,1,0 every 3 cycles, then held 1 -> no pulse during the bounce; single pulse 10 edges after the final rise.
- Release bounce: from PRESSED, boton_i = 0 for 5 cycles, 1 for 2, 0 held -> boton_estable_o stays 1 until 10 edges after the final fall, then 0; no pulse at any point.
- Switches: switches_raw_i 0x0000 -> 0xA5A5 stable -> switches_o = 0xA5A5 after edge 10. A 4-cycle glitch to 0xFFFF -> switches_o unchanged.
- Reset mid-count: assert reset_i while in PRESS_CHK at cnt_b=5 -> outputs 0 immediately (asynchronous). After release with boton_i still held, one pulse after SYNC_STAGES+8 edges.
- With AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5, button held -> pulses at commit, commit+20, commit+25, commit+30; none after release.

Source files
------------

// File: rtl/debouncer_boton_switches.sv
// rtl/debouncer_boton_switches.sv - push-button and slide-switch synchronizer/debouncer
//
// Purpose:
//   Conditions the raw board push-button and slide switches before they reach
//   the memory-mapped switches/button register. Every raw input bit passes
//   through a SYNC_STAGES-deep synchronizer chain. The last stage then feeds
//   one of two paths:
//     - a four-state button FSM that produces a debounced level and a
//       registered one-cycle pulse per accepted press;
//     - a whole-vector switch filter that copies the switch vector to its
//       output once the vector has been stable long enough.
//
// Optional feature macro: AUTOREPEAT_EN
//   When defined, holding the button pressed produces extra pulses.
//   The first extra pulse comes REPEAT_DELAY cycles after the commit.
//   Later pulses follow every REPEAT_PERIOD cycles.
//   When undefined, each press gives exactly one pulse and no repeat counter
//   is built.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a level (>= 2)
//   SYNC_STAGES      flops per synchronizer chain (>= 2)
//   SW_WIDTH         number of slide switches
//   REPEAT_DELAY     cycles held before the first auto-repeat pulse
//   REPEAT_PERIOD    cycles between later auto-repeat pulses
//
// Ports:
//   clk_i            system clock
//   reset_i          asynchronous, active-high reset
//   boton_i          raw, bouncing push-button (1 = pressed)
//   switches_raw_i   raw slide switches
//   pulso_boton_o    one-cycle pulse per accepted press
//   boton_estable_o  debounced button level
//   switches_o       debounced switch vector

module debouncer_boton_switches #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SYNC_STAGES     = 2,
   parameter int SW_WIDTH        = 16,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                boton_i,
   input  logic [SW_WIDTH-1:0] switches_raw_i,
   output logic                pulso_boton_o,
   output logic                boton_estable_o,
   output logic [SW_WIDTH-1:0] switches_o
);

   // Both counters only ever hold 0..DEBOUNCE_CYCLES-1.
   // The commit fires on the edge that would take the count to
   // DEBOUNCE_CYCLES, so that value is never stored.
   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // ------------------------------------------------------------------
   // Synchronizers
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0]               b_sync;
   logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sync;
   logic                                 b_s;
   logic [SW_WIDTH-1:0]                  sw_s;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         b_sync  <= '0;
         sw_sync <= '0;
      end else begin
         b_sync  <= {b_sync[SYNC_STAGES-2:0], boton_i};
         sw_sync <= {sw_sync[SYNC_STAGES-2:0], switches_raw_i};
      end
   end

   assign b_s  = b_sync[SYNC_STAGES-1];
   assign sw_s = sw_sync[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Button FSM
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      PRESS_CHK   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_CHK = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt_b;

`ifdef AUTOREPEAT_EN
   // cnt_r runs 0..REPEAT_DELAY+REPEAT_PERIOD-1.
   // After the first repeat it folds back to REPEAT_DELAY, so every later
   // pass through the top value is exactly REPEAT_PERIOD cycles apart.
   localparam int               REP_W      = $clog2(REPEAT_DELAY + REPEAT_PERIOD);
   localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);
   localparam logic [REP_W-1:0] REP_FIRST  = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] REP_WRAP   = REP_W'(REPEAT_DELAY + REPEAT_PERIOD - 1);
   localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY);

   logic [REP_W-1:0] cnt_r;
`else
   // The repeat parameters have no effect here. This check keeps them
   // referenced without adding any hardware.
   if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_repeat_cfg_unused
   end
`endif

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state           <= IDLE;
         cnt_b           <= '0;
         pulso_boton_o   <= 1'b0;
         boton_estable_o <= 1'b0;
`ifdef AUTOREPEAT_EN
         cnt_r           <= '0;
`endif
      end else begin
         // The pulse is high for one cycle only. Any branch below that
         // wants a pulse sets it again for that single edge.
         pulso_boton_o <= 1'b0;

         case (state)
            IDLE: begin
               boton_estable_o <= 1'b0;
               if (b_s) begin
                  // This edge counts as the first stable-high sample.
                  state <= PRESS_CHK;
                  cnt_b <= CNT_ONE;
               end
            end

            PRESS_CHK: begin
               if (!b_s) begin
                  state <= IDLE;
                  cnt_b <= '0;
               end else if (cnt_b == CNT_LAST) begin
                  // Sample DEBOUNCE_CYCLES: accept the press.
                  state           <= PRESSED;
                  cnt_b           <= '0;
                  pulso_boton_o   <= 1'b1;
                  boton_estable_o <= 1'b1;
`ifdef AUTOREPEAT_EN
                  cnt_r           <= '0;
`endif
               end else begin
                  cnt_b <= cnt_b + CNT_ONE;
               end
            end

            PRESSED: begin
               boton_estable_o <= 1'b1;
               if (!b_s) begin
                  state <= RELEASE_CHK;
                  cnt_b <= CNT_ONE;
               end
`ifdef AUTOREPEAT_EN
               else if (cnt_r == REP_WRAP) begin
                  cnt_r         <= REP_RELOAD;
                  pulso_boton_o <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + REP_ONE;
                  if (cnt_r == REP_FIRST) begin
                     pulso_boton_o <= 1'b1;
                  end
               end
`endif
            end

            RELEASE_CHK: begin
               // While release is being confirmed, the level stays high
               // and cnt_r holds its value.
               if (b_s) begin
                  state <= PRESSED;
                  cnt_b <= '0;
               end else if (cnt_b == CNT_LAST) begin
                  state           <= IDLE;
                  cnt_b           <= '0;
                  boton_estable_o <= 1'b0;
`ifdef AUTOREPEAT_EN
                  cnt_r           <= '0;
`endif
               end else begin
                  cnt_b <= cnt_b + CNT_ONE;
               end
            end

            default: begin
               state <= IDLE;
               cnt_b <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Switch filter
   // ------------------------------------------------------------------
   // The whole vector is treated as one value.
   // sw_prev is the synchronized vector from the previous cycle. Any change
   // to the candidate value restarts the count at 1, so only an unbroken
   // run of DEBOUNCE_CYCLES identical samples reaches the output.
   logic [SW_WIDTH-1:0] sw_prev;
   logic [CNT_W-1:0]    cnt_s;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         sw_prev    <= '0;
         cnt_s      <= '0;
         switches_o <= '0;
      end else begin
         sw_prev <= sw_s;
         if (sw_s == switches_o) begin
            cnt_s <= '0;
         end else if (sw_s != sw_prev) begin
            cnt_s <= CNT_ONE;
         end else if (cnt_s == CNT_LAST) begin
            switches_o <= sw_s;
            cnt_s      <= '0;
         end else begin
            cnt_s <= cnt_s + CNT_ONE;
         end
      end
   end

endmodule
